aclk_keypad_scanner: RTL and testbench
======================================

Name: aclk_keypad_scanner

Overview:
- Upstream stage of the alarm-clock controller. Scans a 4-row x 3-column matrix keypad and debounces key presses.
- Presents a stable 4-bit key code to the controller's key input:
  - 0-9 while a digit key is held.
  - 10 (NOKEY) when no key is held.
- Also gives a one-cycle strobe per accepted press. The controller relies on key staying non-10 for the whole press and returning to 10 only after a debounced release.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven before rows are sampled (>=1).
- DEBOUNCE, 8: consecutive matching cycles needed to accept a press or a release (1..255).
- NOKEY, 10: code output when no valid digit is held.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock is clock.
- row  in  4  keypad row return lines, active-high, already synchronised externally.
- col  out  3  column drive, one-hot active-high.
- key  out  4  registered key code, 0-9 or NOKEY.
- key_valid  out  1  1 when key != NOKEY (combinational from key register).
- key_pulse  out  1  one-cycle strobe when a new digit is accepted.

Behaviour:
- Reset values: col=3'b001, key=NOKEY, key_valid=0, key_pulse=0. State=SCAN, dwell/debounce counter=0, captured row/col=0.
- Key map (col, row0..row3):
  - col0: 1, 4, 7, *
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, #
  - * and # decode to NOKEY.
- SCAN state:
  - col is held and the counter increments each cycle.
  - At counter==SCAN_DIV-1, row is sampled and the counter clears:
    - row==0 or row not one-hot: rotate col 001->010->100->001 and stay in SCAN.
    - row one-hot: capture row and col, go to DEBOUNCE with col frozen.
- DEBOUNCE state:
  - Each cycle, row is compared with the captured value.
  - Mismatch: go to SCAN on the same column, counter=0, key unchanged.
  - Match for DEBOUNCE consecutive cycles: go to HELD and register key<=decode(captured).
  - key_pulse=1 for that single cycle only if the decoded code is 0-9.
- HELD state:
  - col stays frozen.
  - Extra rows asserting alongside the captured row are ignored.
  - Captured row bit low: go to RELEASE with counter=0.
- RELEASE state:
  - Captured bit must stay low for DEBOUNCE consecutive cycles. Then key<=NOKEY, col rotates to the next column, and the state goes to SCAN.
  - Captured bit high again before that: return to HELD with key unchanged and no new pulse.
- Latency: key takes its new value at the clock edge ending the DEBOUNCE-th matching cycle after the sampling edge. key_pulse is high in that same cycle.
- * or # pressed: the full DEBOUNCE/HELD/RELEASE path still runs (the scanner waits for release), but key stays NOKEY and no pulse is given.
- key holds its value through HELD and RELEASE, and changes only on accept or on release-complete.
- Counter is 8 bits wide and saturates at no value beyond max(SCAN_DIV, DEBOUNCE)-1 before it clears.
- Reset asserted mid-press: all outputs go immediately to their reset values. A key still held after reset is re-detected through the normal SCAN/DEBOUNCE path and produces a fresh pulse.
- No state is reachable other than SCAN, DEBOUNCE, HELD and RELEASE. Any illegal encoding goes to SCAN with col=001.

Test Plan (SCAN_DIV=4, DEBOUNCE=8):
- After reset, row=0 for 24 cycles -> col rotates 001,010,100,001,010,100, changing every 4 cycles; key=10, key_pulse never high.
- Hold row=4'b0010 while col=010 -> key=5 at the 8th matching cycle after sampling; key_pulse high exactly 1 cycle; key_valid=1; col frozen at 010 while held.
- Release, then row=0 for 8 cycles -> key=10 at the 8th cycle; col advances to 100; scanning resumes.
- Press row=4'b0001 on col=100 with bounce: low at debounce cycle 3, then stable -> return to SCAN with no key change; the next stable sample is accepted and key=3 with a single pulse.
- HELD on key 8; row drops for 5 cycles and then returns -> key stays 8, no second pulse. A full 8-cycle release then gives key=10.
- Press # (col=100, row=4'b1000) -> key stays 10, no pulse, col frozen until the release is debounced. Then assert reset mid-press of key 7 -> col=001, key=10 immediately, and the held key re-accepted after reset gives exactly one pulse.

Source files
------------

// File: rtl/aclk_keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce for the alarm-clock controller.
// Emits a held digit code (or NOKEY) plus a one-cycle strobe per accepted press.
module aclk_keypad_scanner #(
    parameter int          SCAN_DIV = 4,
    parameter int          DEBOUNCE = 8,
    parameter logic [3:0]  NOKEY    = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_pulse
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // State and dwell/debounce counter kept together so checkers can bind to one signal.
    typedef struct packed {
        state_t     state;
        logic [7:0] cnt;
    } fsm_t;

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);

    fsm_t       fsm_q, fsm_d;
    logic [2:0] col_q, col_d;
    logic [2:0] col_cap_q, col_cap_d;
    logic [3:0] row_cap_q, row_cap_d;
    logic [3:0] key_q, key_d;
    logic       pulse_q, pulse_d;
    logic [3:0] decoded;
    logic       row_hit;

    function automatic logic [2:0] rotate(input logic [2:0] c);
        case (c)
            3'b001:  rotate = 3'b010;
            3'b010:  rotate = 3'b100;
            default: rotate = 3'b001;
        endcase
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] r, input logic [2:0] c);
        logic [3:0] off;
        logic       c_ok;
        decode = NOKEY;
        off    = 4'd0;
        c_ok   = 1'b1;
        case (c)
            3'b001:  off = 4'd0;
            3'b010:  off = 4'd1;
            3'b100:  off = 4'd2;
            default: c_ok = 1'b0;
        endcase
        case (r)
            4'b0001: if (c_ok) decode = 4'd1 + off;
            4'b0010: if (c_ok) decode = 4'd4 + off;
            4'b0100: if (c_ok) decode = 4'd7 + off;
            4'b1000: if (c == 3'b010) decode = 4'd0;
            default: decode = NOKEY;
        endcase
    endfunction

    assign decoded = decode(row_cap_q, col_cap_q);
    // Once held, only the captured row line matters; other rows are ignored.
    assign row_hit = |(row & row_cap_q);

    always_comb begin
        fsm_d     = fsm_q;
        col_d     = col_q;
        col_cap_d = col_cap_q;
        row_cap_d = row_cap_q;
        key_d     = key_q;
        pulse_d   = 1'b0;
        case (fsm_q.state)
            ST_SCAN: begin
                if (fsm_q.cnt >= SCAN_LAST) begin
                    fsm_d.cnt = 8'd0;
                    if ($onehot(row)) begin
                        row_cap_d   = row;
                        col_cap_d   = col_q;
                        fsm_d.state = ST_DEBOUNCE;
                    end else begin
                        col_d = rotate(col_q);
                    end
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 8'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (row != row_cap_q) begin
                    fsm_d.state = ST_SCAN;
                    fsm_d.cnt   = 8'd0;
                end else if (fsm_q.cnt >= DEB_LAST) begin
                    fsm_d.state = ST_HELD;
                    fsm_d.cnt   = 8'd0;
                    key_d       = decoded;
                    pulse_d     = (decoded != NOKEY);
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 8'd1;
                end
            end
            ST_HELD: begin
                if (!row_hit) begin
                    fsm_d.state = ST_RELEASE;
                    fsm_d.cnt   = 8'd0;
                end
            end
            ST_RELEASE: begin
                if (row_hit) begin
                    fsm_d.state = ST_HELD;
                    fsm_d.cnt   = 8'd0;
                end else if (fsm_q.cnt >= DEB_LAST) begin
                    fsm_d.state = ST_SCAN;
                    fsm_d.cnt   = 8'd0;
                    key_d       = NOKEY;
                    col_d       = rotate(col_q);
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 8'd1;
                end
            end
            default: begin
                fsm_d.state = ST_SCAN;
                fsm_d.cnt   = 8'd0;
                col_d       = 3'b001;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q     <= '{state: ST_SCAN, cnt: 8'd0};
            col_q     <= 3'b001;
            col_cap_q <= 3'b000;
            row_cap_q <= 4'b0000;
            key_q     <= NOKEY;
            pulse_q   <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            col_q     <= col_d;
            col_cap_q <= col_cap_d;
            row_cap_q <= row_cap_d;
            key_q     <= key_d;
            pulse_q   <= pulse_d;
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = (key_q != NOKEY);
    assign key_pulse = pulse_q;

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Directed bench for aclk_keypad_scanner: table of key presses plus bounce, glitch and reset sequences.
module tb_aclk_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_pulse;

    // Keypad model: the pressed key drives its row only while its column is driven.
    logic       pressed;
    logic [2:0] col_sel;
    logic [3:0] row_sel;
    assign row = (pressed && (col == col_sel)) ? row_sel : 4'b0000;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [2:0] c;
        logic [3:0] r;
        logic [3:0] exp_key;
        logic       exp_pulse;
        logic [2:0] exp_next_col;
    } vec_t;

    vec_t vecs[8];

    aclk_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(8), .NOKEY(4'd10)) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_pulse (key_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_col(input logic [2:0] target, input bit want_eq, input string name);
        int n = 0;
        while (((col == target) != want_eq) && n < 20) begin
            tick();
            n++;
        end
        if ((col == target) != want_eq) begin
            checks++;
            errors++;
            $display("FAIL %s: col wait timed out, got %0d expected %0d", name, col, target);
        end
    endtask

    // Press a key, wait for its column to come round, then check accept timing.
    task automatic press_accept(input logic [2:0] c, input logic [3:0] r,
                                input logic [3:0] k, input logic p);
        wait_col(c, 1'b0, "pre_press");
        pressed = 1'b1;
        col_sel = c;
        row_sel = r;
        if (p) exp_q.push_back(k);
        wait_col(c, 1'b1, "col_arrive");
        repeat (11) tick();
        check("pre_accept_key", 8'(key), 8'd10);
        check("pre_accept_pulse", 8'(key_pulse), 8'd0);
        tick();
        check("accept_key", 8'(key), 8'(k));
        check("accept_valid", 8'(key_valid), 8'(k != 4'd10));
        check("accept_pulse", 8'(key_pulse), 8'(p));
        tick();
        check("pulse_one_cycle", 8'(key_pulse), 8'd0);
        repeat (3) tick();
        check("held_col_frozen", 8'(col), 8'(c));
        check("held_key", 8'(key), 8'(k));
    endtask

    task automatic release_check(input logic [2:0] c, input logic [3:0] k, input logic [2:0] nc);
        pressed = 1'b0;
        repeat (7) tick();
        check("release_key_hold", 8'(key), 8'(k));
        check("release_col_frozen", 8'(col), 8'(c));
        repeat (2) tick();
        check("release_key", 8'(key), 8'd10);
        check("release_valid", 8'(key_valid), 8'd0);
        check("release_next_col", 8'(col), 8'(nc));
    endtask

    // Scoreboard: every strobe must match the next expected accepted digit.
    always @(negedge clock) begin
        if (!reset && key_pulse) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got key %0d expected no pulse", key);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key !== e) begin
                    errors++;
                    $display("FAIL pulse_key: got %0d expected %0d", key, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b010, 4'b0010, 4'd5,  1'b1, 3'b100};
        vecs[1] = '{3'b001, 4'b0001, 4'd1,  1'b1, 3'b010};
        vecs[2] = '{3'b100, 4'b0100, 4'd9,  1'b1, 3'b001};
        vecs[3] = '{3'b010, 4'b1000, 4'd0,  1'b1, 3'b100};
        vecs[4] = '{3'b100, 4'b1000, 4'd10, 1'b0, 3'b001};
        vecs[5] = '{3'b001, 4'b1000, 4'd10, 1'b0, 3'b010};
        vecs[6] = '{3'b100, 4'b0010, 4'd6,  1'b1, 3'b001};
        vecs[7] = '{3'b001, 4'b0100, 4'd7,  1'b1, 3'b010};

        reset   = 1'b1;
        pressed = 1'b0;
        col_sel = 3'b001;
        row_sel = 4'b0000;
        repeat (2) tick();
        check("reset_col", 8'(col), 8'd1);
        check("reset_key", 8'(key), 8'd10);
        check("reset_valid", 8'(key_valid), 8'd0);
        check("reset_pulse", 8'(key_pulse), 8'd0);
        reset = 1'b0;

        // Idle rotation: column advances every 4 cycles.
        for (int k = 1; k <= 24; k++) begin
            tick();
            if ((k % 4) == 0 || (k % 4) == 3) begin
                logic [2:0] ec;
                ec = 3'b001 << ((k / 4) % 3);
                check("idle_col", 8'(col), 8'(ec));
                check("idle_key", 8'(key), 8'd10);
            end
        end

        for (int i = 0; i < 8; i++) begin
            press_accept(vecs[i].c, vecs[i].r, vecs[i].exp_key, vecs[i].exp_pulse);
            release_check(vecs[i].c, vecs[i].exp_key, vecs[i].exp_next_col);
        end

        // Bounce during debounce: drop at debounce cycle 3, then re-accept.
        wait_col(3'b100, 1'b0, "bounce_pre");
        pressed = 1'b1;
        col_sel = 3'b100;
        row_sel = 4'b0001;
        exp_q.push_back(4'd3);
        wait_col(3'b100, 1'b1, "bounce_arrive");
        repeat (7) tick();
        row_sel = 4'b0000;
        tick();
        check("bounce_col_hold", 8'(col), 8'd4);
        check("bounce_key", 8'(key), 8'd10);
        row_sel = 4'b0001;
        repeat (11) tick();
        check("bounce_pre_accept", 8'(key), 8'd10);
        tick();
        check("bounce_accept_key", 8'(key), 8'd3);
        check("bounce_accept_pulse", 8'(key_pulse), 8'd1);
        tick();
        check("bounce_pulse_one", 8'(key_pulse), 8'd0);
        release_check(3'b100, 4'd3, 3'b001);

        // Held glitch of 5 cycles and extra rows must not disturb key 8.
        press_accept(3'b010, 4'b0100, 4'd8, 1'b1);
        row_sel = 4'b0000;
        repeat (5) tick();
        row_sel = 4'b0100;
        repeat (4) tick();
        check("glitch_key", 8'(key), 8'd8);
        check("glitch_col", 8'(col), 8'd2);
        check("glitch_pulse", 8'(key_pulse), 8'd0);
        row_sel = 4'b0101;
        repeat (4) tick();
        check("extra_row_key", 8'(key), 8'd8);
        row_sel = 4'b0100;
        release_check(3'b010, 4'd8, 3'b100);

        // Reset in the middle of a held press, then re-detection.
        press_accept(3'b001, 4'b0100, 4'd7, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_col", 8'(col), 8'd1);
        check("midreset_key", 8'(key), 8'd10);
        check("midreset_valid", 8'(key_valid), 8'd0);
        check("midreset_pulse", 8'(key_pulse), 8'd0);
        exp_q.push_back(4'd7);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (11) tick();
        check("reaccept_pre", 8'(key), 8'd10);
        tick();
        check("reaccept_key", 8'(key), 8'd7);
        check("reaccept_pulse", 8'(key_pulse), 8'd1);
        tick();
        check("reaccept_pulse_one", 8'(key_pulse), 8'd0);
        release_check(3'b001, 4'd7, 3'b010);

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
